tmds_encoder: RTL and testbench
===============================

// Module: tmds_encoder
// PURPOSE
//  TMDS 8b/10b encoder for one HDMI channel, pixel-clock domain (clk1x).
//  Converts 8-bit video data, or 2 control bits during blanking, into a DC-balanced 10-bit symbol.
//  Feeds the 10-bit parallel input of the downstream 10:1 serializer; dout[0] is transmitted first.
//  One instance per channel (B carries hsync/vsync on c0/c1; G, R tie c0/c1 to 0).
// PARAMETERS
//  CNT_W   5  width of signed running-disparity counter; must be >= 5
//  OUT_INV 0  1 = bitwise-invert dout (P/N-swapped board routing)
// PORTS
//  clk1x  in   1   pixel clock
//  rst_n  in   1   asynchronous active-low reset
//  de     in   1   data enable: 1 = video, 0 = control period
//  din    in   8   pixel component, sampled when de=1
//  c0     in   1   control bit 0, sampled when de=0
//  c1     in   1   control bit 1, sampled when de=0
//  dout   out  10  TMDS symbol to serializer
// BEHAVIOUR
//  - One clock and one reset. rst_n asserts asynchronously and releases synchronously to clk1x.
//  - Reset: all pipeline registers = 0, cnt = 0, dout = 10'h000 (10'h3FF if OUT_INV=1).
//  - Pipeline: 3 stages, no stalls. Input sampled at edge N; matching dout valid after edge N+3.
//  - S1: register de, c0, c1, din; n1d = popcount(din) (4 bits).
//  - S2: build q_m[8:0]. Select XNOR if n1d>4, or if n1d==4 and din[0]==0; otherwise XOR.
//    q_m[0]=din[0]; q_m[i]=q_m[i-1] XOR/XNOR din[i]; q_m[8] = 1 for XOR, 0 for XNOR.
//  - S3: n1q = popcount(q_m[7:0]), n0q = 8-n1q, signed arithmetic at CNT_W bits.
//    de=1, branch a, when cnt==0 or n1q==n0q:
//      dout = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]}
//      cnt += q_m[8] ? (n1q-n0q) : (n0q-n1q)
//    de=1, branch b, when (cnt>0 && n1q>n0q) || (cnt<0 && n0q>n1q):
//      dout = {1'b1, q_m[8], ~q_m[7:0]}; cnt += 2*q_m[8] + (n0q-n1q)
//    de=1, branch c, otherwise:
//      dout = {1'b0, q_m[8], q_m[7:0]}; cnt += (n1q-n0q) - 2*(~q_m[8])
//    de=0: cnt <= 0; dout from {c1,c0}:
//      00 -> 10'b1101010100, 01 -> 10'b0010101011,
//      10 -> 10'b0101010100, 11 -> 10'b1010101011
//  - |cnt| never exceeds 10; no saturation logic required at CNT_W >= 5.
//  - de toggling every cycle is legal. Each symbol is encoded from its own staged de; no bubbles inserted.
//  - Reset mid-stream flushes the pipeline. The first 3 post-reset symbols are control tokens for c=00.
//  - OUT_INV inverts only the final registered dout; cnt logic is unaffected.
// CONFIGURATION
//  TMDS_DISP_MON_EN defined:
//    - Adds output port disp_cnt [CNT_W-1:0] = registered cnt, aligned with dout.
//    - Adds output port disp_err (1 bit), sticky, set when |cnt| > 10; cleared only by rst_n.
//  Not defined: neither port exists; no monitor logic is synthesized.
// TESTING
//  1. rst_n=0, any inputs -> dout=10'h000 immediately (async); stays there while rst_n=0.
//  2. After reset, de=0, {c1,c0}=00/01/10/11 on consecutive cycles
//     -> dout=0x354, 0x0AB, 0x154, 0x2AB, starting 3 cycles later.
//  3. de=1, din=0x00 for 3 cycles from cnt=0
//     -> dout=0x100, 0x3FF, 0x100; disp_cnt (MON_EN) = -8, +2, -6.
//  4. Sequence of test 3, then 1 cycle de=0 (c=00), then din=0x00
//     -> 0x354, then 0x100 again (cnt cleared to 0).
//  5. Random din/de for 1e5 cycles against a reference model
//     -> bit-exact dout; decode(dout)==din; running |cnt|<=10; disp_err stays 0.
//  6. OUT_INV=1, rerun test 2 -> dout = ~expected (0x0AB, 0x354, 0x2AB, 0x154).

Source files
------------

// File: rtl/tmds_encoder.sv
// TMDS 8b/10b encoder for one HDMI channel. Four register levels, so dout lags din by 3 clocks.
// Define TMDS_DISP_MON_EN to add the disparity monitor ports disp_cnt and disp_err.
module tmds_encoder #(
    parameter int unsigned CNT_W   = 5,
    parameter int unsigned OUT_INV = 0
) (
    input  logic             clk1x,
    input  logic             rst_n,
    input  logic             de,
    input  logic [7:0]       din,
    input  logic             c0,
    input  logic             c1,
`ifdef TMDS_DISP_MON_EN
    output logic [CNT_W-1:0] disp_cnt,
    output logic             disp_err,
`endif
    output logic [9:0]       dout
);

    localparam logic [9:0]       DoutRst = (OUT_INV != 0) ? 10'h3FF : 10'h000;
    localparam logic [CNT_W-1:0] Two     = CNT_W'(2);
    localparam logic [CNT_W-1:0] Eight   = CNT_W'(8);

    // Stage 1: input capture and popcount of the raw pixel
    logic       s1_de_q;
    logic [1:0] s1_ctl_q;
    logic [7:0] s1_din_q;
    logic [3:0] s1_n1_q;
    logic [3:0] n1d;

    always_comb begin
        n1d = '0;
        for (int i = 0; i < 8; i++) begin
            n1d = n1d + 4'(din[i]);
        end
    end

    always_ff @(posedge clk1x or negedge rst_n) begin
        if (!rst_n) begin
            s1_de_q  <= 1'b0;
            s1_ctl_q <= 2'b00;
            s1_din_q <= '0;
            s1_n1_q  <= '0;
        end else begin
            s1_de_q  <= de;
            s1_ctl_q <= {c1, c0};
            s1_din_q <= din;
            s1_n1_q  <= n1d;
        end
    end

    // Stage 2: transition-minimised word q_m
    logic       use_xnor;
    logic [8:0] qm;
    logic       s2_de_q;
    logic [1:0] s2_ctl_q;
    logic [8:0] s2_qm_q;

    always_comb begin
        use_xnor = (s1_n1_q > 4'd4) || ((s1_n1_q == 4'd4) && !s1_din_q[0]);
        qm       = '0;
        qm[0]    = s1_din_q[0];
        for (int i = 1; i < 8; i++) begin
            qm[i] = use_xnor ? ~(qm[i-1] ^ s1_din_q[i]) : (qm[i-1] ^ s1_din_q[i]);
        end
        qm[8] = ~use_xnor;
    end

    always_ff @(posedge clk1x or negedge rst_n) begin
        if (!rst_n) begin
            s2_de_q  <= 1'b0;
            s2_ctl_q <= 2'b00;
            s2_qm_q  <= '0;
        end else begin
            s2_de_q  <= s1_de_q;
            s2_ctl_q <= s1_ctl_q;
            s2_qm_q  <= qm;
        end
    end

    // Stage 3: popcount of q_m registered ahead of the disparity loop
    logic [3:0] n1q;
    logic       s3_de_q;
    logic [1:0] s3_ctl_q;
    logic [8:0] s3_qm_q;
    logic [3:0] s3_n1_q;

    always_comb begin
        n1q = '0;
        for (int i = 0; i < 8; i++) begin
            n1q = n1q + 4'(s2_qm_q[i]);
        end
    end

    always_ff @(posedge clk1x or negedge rst_n) begin
        if (!rst_n) begin
            s3_de_q  <= 1'b0;
            s3_ctl_q <= 2'b00;
            s3_qm_q  <= '0;
            s3_n1_q  <= '0;
        end else begin
            s3_de_q  <= s2_de_q;
            s3_ctl_q <= s2_ctl_q;
            s3_qm_q  <= s2_qm_q;
            s3_n1_q  <= n1q;
        end
    end

    // Stage 4: DC balancing; cnt is two's complement, sign taken from the MSB
    logic [CNT_W-1:0] cnt_q, cnt_d, n1_w, bal;
    logic [9:0]       sym, dout_d;
    logic [7:0]       q;
    logic             q8, cnt_zero, cnt_neg, cnt_pos, more_ones, more_zeros;

    always_comb begin
        q          = s3_qm_q[7:0];
        q8         = s3_qm_q[8];
        n1_w       = CNT_W'(s3_n1_q);
        bal        = n1_w + n1_w - Eight;
        cnt_zero   = (cnt_q == '0);
        cnt_neg    = cnt_q[CNT_W-1];
        cnt_pos    = !cnt_zero && !cnt_neg;
        more_ones  = (s3_n1_q > 4'd4);
        more_zeros = (s3_n1_q < 4'd4);
        sym        = '0;
        cnt_d      = cnt_q;
        if (!s3_de_q) begin
            cnt_d = '0;
            case (s3_ctl_q)
                2'b00:   sym = 10'b1101010100;
                2'b01:   sym = 10'b0010101011;
                2'b10:   sym = 10'b0101010100;
                default: sym = 10'b1010101011;
            endcase
        end else if (cnt_zero || (s3_n1_q == 4'd4)) begin
            sym   = {~q8, q8, q8 ? q : ~q};
            cnt_d = q8 ? (cnt_q + bal) : (cnt_q - bal);
        end else if ((cnt_pos && more_ones) || (cnt_neg && more_zeros)) begin
            sym   = {1'b1, q8, ~q};
            cnt_d = cnt_q - bal + (q8 ? Two : '0);
        end else begin
            sym   = {1'b0, q8, q};
            cnt_d = cnt_q + bal - (q8 ? '0 : Two);
        end
        dout_d = (OUT_INV != 0) ? ~sym : sym;
    end

    always_ff @(posedge clk1x or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            dout  <= DoutRst;
        end else begin
            cnt_q <= cnt_d;
            dout  <= dout_d;
        end
    end

`ifdef TMDS_DISP_MON_EN
    logic [CNT_W-1:0] cnt_mag;
    logic             disp_err_q;

    assign cnt_mag  = cnt_q[CNT_W-1] ? ('0 - cnt_q) : cnt_q;
    assign disp_cnt = cnt_q;
    assign disp_err = disp_err_q;

    always_ff @(posedge clk1x or negedge rst_n) begin
        if (!rst_n) begin
            disp_err_q <= 1'b0;
        end else if (cnt_mag > CNT_W'(10)) begin
            disp_err_q <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_tmds_encoder.sv
// Self-checking bench for tmds_encoder: symbol-level reference model, directed literal
// sequences, randomized traffic and a mid-stream asynchronous reset.
module tb_tmds_encoder;

    localparam int CW = 5;

    logic          clk1x = 1'b0;
    logic          rst_n;
    logic          de, c0, c1;
    logic [7:0]    din;
    logic [9:0]    dout, dout_inv;
`ifdef TMDS_DISP_MON_EN
    logic [CW-1:0] disp_cnt, disp_cnt_i;
    logic          disp_err, disp_err_i;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk1x = ~clk1x;

    tmds_encoder #(.CNT_W(CW), .OUT_INV(0)) dut (
        .clk1x    (clk1x),
        .rst_n    (rst_n),
        .de       (de),
        .din      (din),
        .c0       (c0),
        .c1       (c1),
`ifdef TMDS_DISP_MON_EN
        .disp_cnt (disp_cnt),
        .disp_err (disp_err),
`endif
        .dout     (dout)
    );

    tmds_encoder #(.CNT_W(CW), .OUT_INV(1)) dut_inv (
        .clk1x    (clk1x),
        .rst_n    (rst_n),
        .de       (de),
        .din      (din),
        .c0       (c0),
        .c1       (c1),
`ifdef TMDS_DISP_MON_EN
        .disp_cnt (disp_cnt_i),
        .disp_err (disp_err_i),
`endif
        .dout     (dout_inv)
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [9:0] inv10(input logic [9:0] v);
        return ~v;
    endfunction

    function automatic int ones(input logic [7:0] v);
        int n = 0;
        for (int i = 0; i < 8; i++) n += int'(v[i]);
        return n;
    endfunction

    typedef struct packed {
        logic [9:0] sym;
        logic       is_data;
        logic [7:0] d;
        logic [7:0] cnt;
    } exp_t;

    // Encode one symbol straight from the TMDS rules, disparity held as a plain int
    function automatic exp_t encode(input logic e, input logic [7:0] d, input logic [1:0] c,
                                    input int disp_in, output int disp_out);
        exp_t       r;
        int         n1, n0;
        logic [8:0] qv;
        bit         xn;
        r.is_data = e;
        r.d       = d;
        r.sym     = '0;
        disp_out  = 0;
        if (!e) begin
            case (c)
                2'b00:   r.sym = 10'b1101010100;
                2'b01:   r.sym = 10'b0010101011;
                2'b10:   r.sym = 10'b0101010100;
                default: r.sym = 10'b1010101011;
            endcase
        end else begin
            n1    = ones(d);
            xn    = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
            qv    = '0;
            qv[0] = d[0];
            for (int i = 1; i < 8; i++) qv[i] = xn ? ~(qv[i-1] ^ d[i]) : (qv[i-1] ^ d[i]);
            qv[8] = !xn;
            n1    = ones(qv[7:0]);
            n0    = 8 - n1;
            if (disp_in == 0 || n1 == n0) begin
                r.sym    = {~qv[8], qv[8], qv[8] ? qv[7:0] : ~qv[7:0]};
                disp_out = disp_in + (qv[8] ? (n1 - n0) : (n0 - n1));
            end else if ((disp_in > 0 && n1 > n0) || (disp_in < 0 && n0 > n1)) begin
                r.sym    = {1'b1, qv[8], ~qv[7:0]};
                disp_out = disp_in + (qv[8] ? 2 : 0) + (n0 - n1);
            end else begin
                r.sym    = {1'b0, qv[8], qv[7:0]};
                disp_out = disp_in + (n1 - n0) - (qv[8] ? 0 : 2);
            end
        end
        r.cnt = 8'(disp_out);
        return r;
    endfunction

    function automatic logic [7:0] decode(input logic [9:0] s);
        logic [7:0] v, r;
        v    = s[9] ? ~s[7:0] : s[7:0];
        r[0] = v[0];
        for (int i = 1; i < 8; i++) r[i] = s[8] ? (v[i] ^ v[i-1]) : ~(v[i] ^ v[i-1]);
        return r;
    endfunction

    // Reference model: three flushed control-00 symbols precede the first real one
    exp_t pipe_q[$];
    exp_t cur;
    int   model_cnt;

    always @(posedge clk1x or negedge rst_n) begin
        exp_t e, tok;
        int   nd;
        if (!rst_n) begin
            tok.sym     = 10'h354;
            tok.is_data = 1'b0;
            tok.d       = '0;
            tok.cnt     = '0;
            pipe_q      = {tok, tok, tok};
            model_cnt   = 0;
        end else begin
            e         = encode(de, din, {c1, c0}, model_cnt, nd);
            model_cnt = nd;
            pipe_q.push_back(e);
            cur = pipe_q.pop_front();
        end
    end

    always @(negedge clk1x) begin
        if (!rst_n) begin
            check("rst_dout", 16'(dout), 16'h000);
            check("rst_dout_inv", 16'(dout_inv), 16'h3FF);
        end else begin
            check("dout", 16'(dout), 16'(cur.sym));
            check("dout_inv", 16'(dout_inv), 16'(inv10(cur.sym)));
            if (cur.is_data) check("decode", 16'(decode(dout)), 16'(cur.d));
`ifdef TMDS_DISP_MON_EN
            check("disp_cnt", 16'(disp_cnt), 16'(cur.cnt[CW-1:0]));
            check("disp_cnt_inv", 16'(disp_cnt_i), 16'(cur.cnt[CW-1:0]));
            check("disp_err", 16'(disp_err), 16'h0);
`endif
        end
    end

    // Directed sequences with hand-computed expectations
    logic       d_de [8];
    logic [7:0] d_din[8];
    logic [1:0] d_c  [8];
    logic [9:0] d_exp[8];
    int         d_cnt[8];

    task automatic set_stim(input int i, input logic e, input logic [7:0] d, input logic [1:0] c,
                            input logic [9:0] x, input int cn);
        d_de[i]  = e;
        d_din[i] = d;
        d_c[i]   = c;
        d_exp[i] = x;
        d_cnt[i] = cn;
    endtask

    task automatic directed(input int n, input string tag);
        logic [9:0]    e;
        logic [CW-1:0] ec;
        for (int i = 0; i < n + 4; i++) begin
            @(negedge clk1x);
            #1;
            if (i >= 4) begin
                e  = d_exp[i-4];
                ec = CW'(d_cnt[i-4]);
                check({tag, "_dout"}, 16'(dout), 16'(e));
                check({tag, "_dout_inv"}, 16'(dout_inv), 16'(inv10(e)));
`ifdef TMDS_DISP_MON_EN
                check({tag, "_disp_cnt"}, 16'(disp_cnt), 16'(ec));
`endif
            end
            if (i < n) begin
                de = d_de[i];
                din = d_din[i];
                {c1, c0} = d_c[i];
            end else begin
                de = 1'b0;
                din = 8'h00;
                {c1, c0} = 2'b00;
            end
        end
    endtask

    task automatic rand_run(input int n);
        int mode, r;
        for (int k = 0; k < n; k++) begin
            @(negedge clk1x);
            #1;
            mode = (k / 400) % 4;
            case (mode)
                0:       de = 1'($urandom_range(0, 1));
                1:       de = ($urandom_range(0, 15) != 0);
                2:       de = ~de;
                default: de = 1'b1;
            endcase
            r = int'($urandom_range(0, 3));
            if (mode == 3 && r == 0) din = 8'h00;
            else if (mode == 3 && r == 1) din = 8'hFF;
            else din = 8'($urandom);
            {c1, c0} = 2'($urandom);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        de = 1'b0;
        din = 8'h00;
        c0 = 1'b0;
        c1 = 1'b0;
        repeat (3) @(negedge clk1x);
        #1;
        rst_n = 1'b1;

        // Control tokens 00/01/10/11
        set_stim(0, 1'b0, 8'h00, 2'b00, 10'h354, 0);
        set_stim(1, 1'b0, 8'h00, 2'b01, 10'h0AB, 0);
        set_stim(2, 1'b0, 8'h00, 2'b10, 10'h154, 0);
        set_stim(3, 1'b0, 8'h00, 2'b11, 10'h2AB, 0);
        directed(4, "ctl");

        // din=0x00 three times from cnt=0, one blanking symbol, then 0x00 again
        set_stim(0, 1'b1, 8'h00, 2'b00, 10'h100, -8);
        set_stim(1, 1'b1, 8'h00, 2'b00, 10'h3FF, 2);
        set_stim(2, 1'b1, 8'h00, 2'b00, 10'h100, -6);
        set_stim(3, 1'b0, 8'h00, 2'b00, 10'h354, 0);
        set_stim(4, 1'b1, 8'h00, 2'b00, 10'h100, -8);
        directed(5, "zero");

        rand_run(10000);

        // Asynchronous reset mid-stream, away from any clock edge
        @(posedge clk1x);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_dout", 16'(dout), 16'h000);
        check("async_rst_dout_inv", 16'(dout_inv), 16'h3FF);
        repeat (2) @(negedge clk1x);
        #1;
        rst_n = 1'b1;
        de = 1'b0;
        {c1, c0} = 2'b00;

        rand_run(10000);

        @(negedge clk1x);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
